// File: rtl/start_conditioner.sv
// Debounces the active-low start button into one START pulse per press and freezes operands A/B at that press.
// Latency: pin to START is 2 sync + DEBOUNCE_CYCLES + 1 cycles; there is no backpressure, and re-trigger is locked out until END_MULT and release.
module start_conditioner #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         BTN_N,
  input  logic [N-1:0] SW_A,
  input  logic [N-1:0] SW_B,
  input  logic         END_MULT,
  output logic         START,
  output logic [N-1:0] A_OUT,
  output logic [N-1:0] B_OUT,
  output logic         BUSY
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_END, WAIT_REL} state_t;

  state_t        state, state_nx;
  logic          btn_m, btn_s, btn_db;
  logic [CW-1:0] db_cnt, rel_cnt;
  logic          armed, rel_ok, load;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      btn_m <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      btn_m <= BTN_N;
      btn_s <= btn_m;
    end
  end

  // The counter holds at most DEBOUNCE_CYCLES-1; the accepting cycle is the one that would reach DEBOUNCE_CYCLES.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_LAST) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // btn_db resets to "released", so a button held through reset would look like a fresh press.
  // Presses are therefore ignored until a genuine, debounced release has been observed.
  assign rel_ok = btn_m & btn_s;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      armed   <= 1'b0;
      rel_cnt <= '0;
    end else if (!armed) begin
      if (!rel_ok)
        rel_cnt <= '0;
      else if (rel_cnt != CNT_MAX)
        rel_cnt <= rel_cnt + 1'b1;
      if (rel_ok && btn_db && rel_cnt == CNT_MAX)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // IDLE is only entered with btn_db high, so btn_db low in IDLE means a debounced falling edge.
  always_comb begin
    state_nx = state;
    START    = 1'b0;
    BUSY     = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !btn_db)
          state_nx = ISSUE;
      end
      ISSUE: begin
        START    = 1'b1;
        BUSY     = 1'b1;
        load     = 1'b1;
        state_nx = WAIT_END;
      end
      WAIT_END: begin
        BUSY = 1'b1;
        if (END_MULT)
          state_nx = btn_db ? IDLE : WAIT_REL;
      end
      WAIT_REL: begin
        if (btn_db)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      A_OUT <= '0;
      B_OUT <= '0;
    end else if (load) begin
      A_OUT <= SW_A;
      B_OUT <= SW_B;
    end
  end

endmodule

// File: tb/tb_start_conditioner.sv
// Bench for start_conditioner with DEBOUNCE_CYCLES=4: a press table plus hand-written corner sequences,
// and a START monitor that pops the expected operands and press time from a scoreboard queue.
module tb_start_conditioner;

  localparam int N     = 8;
  localparam int DB    = 4;
  localparam int PRESS_LAT = 2 + DB + 1;

  typedef struct {
    logic [7:0] sw_a;
    logic [7:0] sw_b;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         t0;
  } exp_t;

  logic         clk;
  logic         RESET;
  logic         BTN_N;
  logic [N-1:0] SW_A;
  logic [N-1:0] SW_B;
  logic         END_MULT;
  logic         START;
  logic [N-1:0] A_OUT;
  logic [N-1:0] B_OUT;
  logic         BUSY;

  int   n_checks;
  int   n_fail;
  int   cyc;
  int   start_cnt;
  int   base;
  int   run;
  int   t;
  logic lvl;
  logic busy_seen;
  logic prev_start;
  logic pend;
  exp_t cur;
  exp_t exp_q[$];
  vec_t vecs[5];

  start_conditioner #(.N(N), .DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK    (clk),
    .RESET    (RESET),
    .BTN_N    (BTN_N),
    .SW_A     (SW_A),
    .SW_B     (SW_B),
    .END_MULT (END_MULT),
    .START    (START),
    .A_OUT    (A_OUT),
    .B_OUT    (B_OUT),
    .BUSY     (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.a  = a;
    e.b  = b;
    e.t0 = cyc;
    exp_q.push_back(e);
    BTN_N = 1'b0;
  endtask

  task automatic wait_starts(input int target);
    int i = 0;
    while (start_cnt < target && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("start_seen", 32'(start_cnt), 32'(target));
  endtask

  task automatic end_pulse();
    END_MULT = 1'b1;
    tick(1);
    END_MULT = 1'b0;
    check("busy_cleared", 32'(BUSY), 32'd0);
  endtask

  // Scoreboard side: every START must match a queued press, with the fixed latency and operands.
  initial begin
    prev_start = 1'b0;
    pend       = 1'b0;
    start_cnt  = 0;
  end

  always @(negedge clk) begin
    if (pend) begin
      check("a_out_latched", 32'(A_OUT), 32'(cur.a));
      check("b_out_latched", 32'(B_OUT), 32'(cur.b));
      check("busy_after_start", 32'(BUSY), 32'd1);
      pend = 1'b0;
    end
    if (START) begin
      check("start_width", 32'(prev_start), 32'd0);
      start_cnt++;
      check("start_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        check("press_latency", 32'(cyc - cur.t0), 32'(PRESS_LAT));
        pend = 1'b1;
      end
    end
    prev_start = START;
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{8'hFB, 8'h07, 8'hFB, 8'h07};
    vecs[1]  = '{8'h80, 8'h7F, 8'h80, 8'h7F};
    vecs[2]  = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[3]  = '{8'h7F, 8'h80, 8'h7F, 8'h80};
    vecs[4]  = '{8'h55, 8'hAA, 8'h55, 8'hAA};

    RESET    = 1'b1;
    BTN_N    = 1'b1;
    SW_A     = '0;
    SW_B     = '0;
    END_MULT = 1'b0;
    tick(3);
    RESET = 1'b0;
    tick(1);
    check("rst_start", 32'(START), 32'd0);
    check("rst_busy",  32'(BUSY),  32'd0);
    check("rst_a_out", 32'(A_OUT), 32'd0);
    check("rst_b_out", 32'(B_OUT), 32'd0);

    // Bounce rejection: runs of 1..3 cycles never satisfy a 4-cycle debounce.
    SW_A      = 8'hFB;
    SW_B      = 8'h07;
    busy_seen = 1'b0;
    lvl       = 1'b0;
    t         = 0;
    while (t < 40) begin
      run   = $urandom_range(1, 3);
      BTN_N = lvl;
      repeat (run) begin
        @(negedge clk);
        busy_seen = busy_seen | BUSY | START;
      end
      t   = t + run;
      lvl = ~lvl;
    end
    BTN_N = 1'b1;
    repeat (20) begin
      @(negedge clk);
      busy_seen = busy_seen | BUSY | START;
    end
    check("bounce_no_start", 32'(start_cnt), 32'd0);
    check("bounce_no_busy",  32'(busy_seen), 32'd0);
    check("bounce_a_out",    32'(A_OUT), 32'd0);
    check("bounce_b_out",    32'(B_OUT), 32'd0);

    // Clean presses with operand freeze while waiting for END_MULT.
    for (int i = 0; i < 5; i++) begin
      base = start_cnt;
      SW_A = vecs[i].sw_a;
      SW_B = vecs[i].sw_b;
      press(vecs[i].exp_a, vecs[i].exp_b);
      wait_starts(base + 1);
      tick(2);
      SW_A = ~vecs[i].sw_a;
      SW_B = ~vecs[i].sw_b;
      tick(5);
      check("a_out_frozen", 32'(A_OUT), 32'(vecs[i].exp_a));
      check("b_out_frozen", 32'(B_OUT), 32'(vecs[i].exp_b));
      check("busy_wait_end", 32'(BUSY), 32'd1);
      end_pulse();
      BTN_N = 1'b1;
      tick(12);
      check("single_start", 32'(start_cnt), 32'(base + 1));
    end

    // Held button across END_MULT, then release and re-press with new operands.
    base = start_cnt;
    SW_A = 8'h12;
    SW_B = 8'h34;
    press(8'h12, 8'h34);
    wait_starts(base + 1);
    tick(2);
    end_pulse();
    busy_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      busy_seen = busy_seen | BUSY;
    end
    check("held_no_restart", 32'(start_cnt), 32'(base + 1));
    check("held_not_busy",   32'(busy_seen), 32'd0);
    BTN_N = 1'b1;
    tick(12);
    SW_A = 8'h80;
    SW_B = 8'h7F;
    press(8'h80, 8'h7F);
    wait_starts(base + 2);
    tick(2);
    end_pulse();
    BTN_N = 1'b1;
    tick(12);

    // Release while still waiting: BUSY must hold until END_MULT arrives.
    base = start_cnt;
    SW_A = 8'hC8;
    SW_B = 8'h19;
    press(8'hC8, 8'h19);
    wait_starts(base + 1);
    tick(2);
    BTN_N = 1'b1;
    tick(12);
    check("busy_after_release", 32'(BUSY), 32'd1);
    end_pulse();
    tick(4);

    // Spurious END_MULT in IDLE and during the ISSUE cycle.
    base     = start_cnt;
    END_MULT = 1'b1;
    tick(5);
    END_MULT = 1'b0;
    check("idle_endmult_busy",  32'(BUSY), 32'd0);
    check("idle_endmult_start", 32'(start_cnt), 32'(base));
    SW_A = 8'h5A;
    SW_B = 8'hA5;
    press(8'h5A, 8'hA5);
    tick(PRESS_LAT);
    check("issue_cycle_start", 32'(START), 32'd1);
    END_MULT = 1'b1;
    tick(1);
    END_MULT = 1'b0;
    check("issue_endmult_ignored", 32'(BUSY), 32'd1);
    tick(5);
    check("busy_still_high", 32'(BUSY), 32'd1);
    end_pulse();
    BTN_N = 1'b1;
    tick(12);

    // Synchronous reset in WAIT_END with the button held.
    base = start_cnt;
    SW_A = 8'h3C;
    SW_B = 8'hC3;
    press(8'h3C, 8'hC3);
    wait_starts(base + 1);
    tick(3);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("midop_rst_start", 32'(START), 32'd0);
    check("midop_rst_busy",  32'(BUSY),  32'd0);
    check("midop_rst_a_out", 32'(A_OUT), 32'd0);
    check("midop_rst_b_out", 32'(B_OUT), 32'd0);
    tick(30);
    check("held_after_reset", 32'(start_cnt), 32'(base + 1));
    BTN_N = 1'b1;
    tick(15);
    SW_A = 8'h66;
    SW_B = 8'h99;
    press(8'h66, 8'h99);
    wait_starts(base + 2);
    tick(2);
    end_pulse();
    BTN_N = 1'b1;
    tick(12);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/start_conditioner.md
# start_conditioner

Front-end stage for the sequential multiplier on the EP4CE115F29C7 board. It turns the raw, bouncing, active-low start push-button into exactly one clean single-cycle START pulse per physical press. It freezes the switch operands A and B at that press and holds them stable for the whole operation. It locks out re-triggering until the multiplier reports END_MULT and the button has been released. It sits between the board pins (BTN_START, SW_A, SW_B) and the multiplier's START/A/B inputs.

## Interface
- N, 8: operand width in bits (signed two's complement, passed through unchanged).
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz); minimum 2. Counter width is $clog2(DEBOUNCE_CYCLES+1).

- CLOCK  in  1  board clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- BTN_N  in  1  raw start button, asynchronous, active-low (0 = pressed).
- SW_A  in  N  raw operand A switches.
- SW_B  in  N  raw operand B switches.
- END_MULT  in  1  completion flag from the multiplier.
- START  out  1  single-cycle start pulse to the multiplier, active-high.
- A_OUT  out  N  latched operand A.
- B_OUT  out  N  latched operand B.
- BUSY  out  1  high from the START cycle until END_MULT is accepted.

## Operation
- Synchronizer: BTN_N passes through 2 flip-flops to give btn_s. Both flops reset to 1 (released).
- Debouncer: registered level btn_db resets to 1. A counter increments each cycle btn_s != btn_db and clears to 0 in any cycle btn_s == btn_db. When the counter reaches DEBOUNCE_CYCLES, btn_db takes btn_s and the counter clears. Any bounce shorter than DEBOUNCE_CYCLES is discarded.
- FSM, reset state IDLE:
  - IDLE: BTN_N low-going debounced edge (btn_db 1→0) → ISSUE. END_MULT is ignored.
  - ISSUE, exactly 1 cycle: START=1 and BUSY=1. A_OUT<=SW_A and B_OUT<=SW_B are loaded on this cycle's clock edge. Always → WAIT_END.
  - WAIT_END: BUSY=1. END_MULT==1 → BUSY falls. If btn_db==1 at that point → IDLE, else → WAIT_REL.
  - WAIT_REL: BUSY=0. btn_db==1 → IDLE. A held button never causes a second START.
- A_OUT and B_OUT change only on the ISSUE edge. Switch activity at any other time has no effect on them.
- No arithmetic is performed. Operands are copied bit-exact, with sign carried implicitly.

## Timing
- Reset values: START=0, BUSY=0, A_OUT=0, B_OUT=0, btn_db=1, counter=0, state IDLE.
- Reset is synchronous and wins over every other event, including mid-ISSUE or mid-WAIT_END. If the button is still held after reset, btn_db must first see a release and then a new debounced press before START can fire.
- Press latency, counting from the first cycle in which btn_s==0 and stays low:
  - btn_db falls after DEBOUNCE_CYCLES cycles.
  - START is high in the next cycle.
  - Raw pin to START is 2 + DEBOUNCE_CYCLES + 1 cycles.
- START is high for exactly 1 cycle per accepted press.
- END_MULT sampled in the ISSUE cycle is ignored. Only WAIT_END samples it.
- BUSY deasserts on the edge after END_MULT is sampled high.
- If END_MULT and a debounced release occur in the same cycle in WAIT_END → IDLE directly.
- The counter cannot wrap: it clears at DEBOUNCE_CYCLES.

## Test plan
(All scenarios use DEBOUNCE_CYCLES=4.)
- Bounce rejection: BTN_N toggles low/high in runs of 1–3 cycles for 40 cycles, then stays high → START never asserted, BUSY stays 0, A_OUT/B_OUT stay 0x00.
- Clean press: SW_A=0xFB (−5), SW_B=0x07; BTN_N goes low and stays low → START high for exactly 1 cycle, 7 cycles after the BTN_N edge. Next cycle A_OUT=0xFB, B_OUT=0x07, BUSY=1.
- Operand freeze: during WAIT_END, set SW_A=0x80 and SW_B=0x7F → A_OUT=0xFB and B_OUT=0x07 are unchanged. END_MULT pulse → BUSY=0 one cycle later.
- Held button: button kept low through END_MULT for 100 cycles → no second START. Release and press again → one START, with new operands latched (0x80, 0x7F).
- Reset mid-operation: RESET=1 for 1 cycle in WAIT_END with the button held → next cycle START=0, BUSY=0, A_OUT=B_OUT=0x00. No START until release followed by a new press.
- Spurious completion: END_MULT=1 while in IDLE and during the ISSUE cycle → no state change from IDLE. When END_MULT comes during ISSUE, BUSY stays 1 until a later END_MULT arrives in WAIT_END.
